// File: rtl/mul_add_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_add_seq_if
//  Description : Operand/result bundle for the sequential multiply-add unit.
//                The master side launches an operation and the slave side
//                returns the result and status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul_add_seq_if;
  logic        start;
  logic [31:0] a;
  logic [15:0] b;
  logic [15:0] c;
  logic [47:0] p;
  logic        busy;
  logic        ready;
  logic [4:0]  count;

  modport master (
    output start, a, b, c,
    input  p, busy, ready, count
  );

  modport slave (
    input  start, a, b, c,
    output p, busy, ready, count
  );
endinterface
`default_nettype wire

// File: rtl/mul_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mul_add_seq
//  Description : Sequential shift-add unit computing p = a*b + c (unsigned,
//                exact, 48-bit result). Used to rebuild a dividend from a
//                quotient (a), divisor (b) and remainder (c).
//                Optional macro MUL_ADD_RADIX4_EN retires two multiplier bits
//                per iteration (16 busy cycles instead of 32).
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_add_seq (
  input  wire logic    clk,
  input  wire logic    clrn,
  mul_add_seq_if.slave bus
);

`ifdef MUL_ADD_RADIX4_EN
  localparam int          HI_W = 18;
  localparam logic [4:0]  LAST = 5'd15;
`else
  localparam int          HI_W = 17;
  localparam logic [4:0]  LAST = 5'd31;
`endif

  logic [HI_W-1:0] acc_hi;
  logic [31:0]     acc_lo;
  logic [15:0]     reg_b;
  logic [4:0]      count;
  logic            busy;
  logic            ready;

  logic [HI_W-1:0] sum;
  logic [HI_W-1:0] next_hi;
  logic [31:0]     next_lo;

`ifdef MUL_ADD_RADIX4_EN
  // 3*b is formed once at start so each iteration only needs one adder.
  logic [17:0]     reg_b3;
  logic [17:0]     addend;

  // Select the partial product for the two retiring multiplier bits and shift by two.
  always_comb begin
    addend = '0;
    case (acc_lo[1:0])
      2'd0:    addend = '0;
      2'd1:    addend = {2'b00, reg_b};
      2'd2:    addend = {1'b0, reg_b, 1'b0};
      default: addend = reg_b3;
    endcase
    sum     = acc_hi + addend;
    next_hi = {2'b00, sum[17:2]};
    next_lo = {sum[1:0], acc_lo[31:2]};
  end

  // Hold the precomputed triple multiplicand for the whole operation.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      reg_b3 <= '0;
    end else if (bus.start) begin
      reg_b3 <= {2'b00, bus.b} + {1'b0, bus.b, 1'b0};
    end
  end
`else
  // Add the multiplicand when the retiring multiplier bit is set, then shift by one.
  always_comb begin
    sum     = acc_hi + (acc_lo[0] ? {1'b0, reg_b} : {HI_W{1'b0}});
    next_hi = {1'b0, sum[16:1]};
    next_lo = {sum[0], acc_lo[31:1]};
  end
`endif

  // Operation control and datapath: start has priority and may abort a running operation.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      acc_hi <= '0;
      acc_lo <= '0;
      reg_b  <= '0;
      count  <= '0;
      busy   <= 1'b0;
      ready  <= 1'b0;
    end else if (bus.start) begin
      acc_hi <= {{(HI_W-16){1'b0}}, bus.c};
      acc_lo <= bus.a;
      reg_b  <= bus.b;
      count  <= '0;
      busy   <= 1'b1;
      ready  <= 1'b0;
    end else if (busy) begin
      acc_hi <= next_hi;
      acc_lo <= next_lo;
      count  <= count + 5'd1;
      if (count == LAST) begin
        busy  <= 1'b0;
        ready <= 1'b1;
      end
    end
  end

  // The addend c starts in the high half and is shifted down 32 places by the
  // end, so the final register pair holds exactly a*b + c.
  assign bus.p     = {acc_hi[15:0], acc_lo};
  assign bus.busy  = busy;
  assign bus.ready = ready;
  assign bus.count = count;

endmodule
`default_nettype wire

// File: tb/tb_mul_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_add_seq
//  Description : Directed vector bench for mul_add_seq, with hand-written
//                sequences for restart, reset and hold, plus a divider
//                round-trip sweep. Honours MUL_ADD_RADIX4_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_add_seq;

`ifdef MUL_ADD_RADIX4_EN
  localparam int LAT     = 16;
  localparam int END_CNT = 16;
`else
  localparam int LAT     = 32;
  localparam int END_CNT = 0;
`endif

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  mul_add_seq_if bus ();

  mul_add_seq dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  int checks = 0;
  int errs   = 0;

  typedef struct {
    logic [31:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [47:0] p;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Launch an operation; operands are scrambled afterwards since they must be ignored.
  task automatic start_op(input logic [31:0] a, input logic [15:0] b, input logic [15:0] c);
    bus.a     = a;
    bus.b     = b;
    bus.c     = c;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("start_busy",  {63'd0, bus.busy},  64'd1);
    check("start_ready", {63'd0, bus.ready}, 64'd0);
    check("start_count", {59'd0, bus.count}, 64'd0);
    bus.a = $urandom;
    bus.b = 16'($urandom);
    bus.c = 16'($urandom);
  endtask

  // Count edges until ready, bounded so a stuck design still reaches the summary.
  task automatic wait_ready(output int n);
    int overlap;
    overlap = 0;
    n = 0;
    while (n < LAT + 10) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.busy && bus.ready) overlap++;
      if (bus.ready) break;
    end
    check("busy_ready_overlap", 64'(overlap), 64'd0);
  endtask

  initial begin
    int n;
    logic [31:0] d, q;
    logic [15:0] v, r;

    vecs[0] = '{32'h0000_0007, 16'h0003, 16'h0002, 48'h0000_0000_0017};
    vecs[1] = '{32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 48'hFFFF_0000_0000};
    vecs[2] = '{32'h0000_DEAD, 16'h0000, 16'h1234, 48'h0000_0000_1234};
    vecs[3] = '{32'h0000_0000, 16'hFFFF, 16'h0005, 48'h0000_0000_0005};
    vecs[4] = '{32'h0000_0001, 16'hABCD, 16'h0000, 48'h0000_0000_ABCD};
    vecs[5] = '{32'h1234_5678, 16'h1000, 16'h0000, 48'h0123_4567_8000};
    vecs[6] = '{32'h8000_0000, 16'h0002, 16'h0001, 48'h0001_0000_0001};
    vecs[7] = '{32'h0002_2E09, 16'h0007, 16'h0001, 48'h0000_000F_4240};
    vecs[8] = '{32'h0001_0001, 16'hFFFF, 16'h0000, 48'h0000_FFFF_FFFF};
    vecs[9] = '{32'h0000_0000, 16'h0000, 16'h0000, 48'h0000_0000_0000};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.c     = '0;
    clrn      = 1'b0;
    #2;
    check("reset_p",     {16'd0, bus.p},     64'd0);
    check("reset_busy",  {63'd0, bus.busy},  64'd0);
    check("reset_ready", {63'd0, bus.ready}, 64'd0);
    check("reset_count", {59'd0, bus.count}, 64'd0);
    #10;
    clrn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", {63'd0, bus.busy},  64'd0);
    check("idle_p",    {16'd0, bus.p},     64'd0);

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].c);
      wait_ready(n);
      check("vec_latency", 64'(n), 64'(LAT));
      check("vec_p",       {16'd0, bus.p},     {16'd0, vecs[i].p});
      check("vec_busy",    {63'd0, bus.busy},  64'd0);
      check("vec_count",   {59'd0, bus.count}, 64'(END_CNT));
    end

    // Zero multiplicand then long hold with start low
    start_op(32'h0000_BEEF, 16'h0000, 16'h1234);
    wait_ready(n);
    check("hold_latency", 64'(n), 64'(LAT));
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      bus.a = $urandom;
      bus.b = 16'($urandom);
      bus.c = 16'($urandom);
      check("hold_ready", {63'd0, bus.ready}, 64'd1);
      check("hold_p",     {16'd0, bus.p},     64'h1234);
    end

    // Restart at busy cycle 10
    start_op(32'h0000_0007, 16'h0003, 16'h0002);
    repeat (10) @(posedge clk);
    #1;
    check("restart_mid_count", {59'd0, bus.count}, 64'd10);
    start_op(32'd5, 16'd5, 16'd0);
    wait_ready(n);
    check("restart_latency", 64'(n), 64'(LAT));
    check("restart_p",       {16'd0, bus.p}, 64'd25);

    // Asynchronous reset at busy cycle 20, applied mid-cycle
    start_op(32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF);
    repeat (20) @(posedge clk);
    #3;
    clrn = 1'b0;
    #1;
    check("areset_busy",  {63'd0, bus.busy},  64'd0);
    check("areset_ready", {63'd0, bus.ready}, 64'd0);
    check("areset_p",     {16'd0, bus.p},     64'd0);
    check("areset_count", {59'd0, bus.count}, 64'd0);
    #2;
    clrn = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post_reset_busy",  {63'd0, bus.busy},  64'd0);
    check("post_reset_ready", {63'd0, bus.ready}, 64'd0);
    check("post_reset_p",     {16'd0, bus.p},     64'd0);
    start_op(32'd3, 16'd4, 16'd5);
    wait_ready(n);
    check("post_reset_op_p", {16'd0, bus.p}, 64'd17);

    // Divider round trip: quotient*divisor + remainder rebuilds the dividend
    for (int i = 0; i < 200; i++) begin
      d = $urandom;
      v = 16'($urandom_range(1, 65535));
      q = d / {16'd0, v};
      r = 16'(d % {16'd0, v});
      start_op(q, v, r);
      wait_ready(n);
      check("roundtrip_p", {16'd0, bus.p}, {32'd0, d});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
`default_nettype wire
